pi_host_port: RTL and testbench

Pi-side host register front end for the PiStorm CPLD, clocked by the Pi clock `c200m`. It sits directly upstream of the 68K bus-cycle engine. It edge-detects the Pi `PI_RD`/`PI_WR` strobes, decodes the 2-bit register address, and latches A0 and the size/direction bits into a transaction descriptor. It then drives an `op_req`/`op_ack`/`op_done` handshake to the engine. It also owns the control/status register, a busy watchdog and sticky error flags.

---
 rtl/pistorm_pkg.sv | 47 ++++
 rtl/pi_strobe_sync.sv | 22 ++
 rtl/pi_host_port.sv | 158 +++++++++++++++
 tb/tb_pi_host_port.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pistorm_pkg.sv
// Shared register map, FSM encoding and STATUS layout for the PiStorm Pi-side host port.
// STATUS readback: ipl in [15:13], sticky flags and live state in [4:0].
package pistorm_pkg;

    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_ADDR_LO = 2'd1;
    localparam logic [1:0] REG_ADDR_HI = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_REQ   = 2'd2,
        ST_BUSY  = 2'd3
    } host_state_t;

    localparam int STAT_TXN      = 0;
    localparam int STAT_RUN      = 1;
    localparam int STAT_BUSY     = 2;
    localparam int STAT_OVERRUN  = 3;
    localparam int STAT_TIMEOUT  = 4;
    localparam int STAT_IPL_LSB  = 13;

    // ctrl[1] releases the 68K from reset; ctrl[15] on write clears the sticky flags.
    localparam int CTRL_RUN_BIT  = 1;
    localparam int CTRL_CLR_BIT  = 15;

    function automatic logic [15:0] pack_status(
        input logic [2:0] ipl,
        input logic       timeout,
        input logic       overrun,
        input logic       busy,
        input logic       run,
        input logic       txn
    );
        logic [15:0] s;
        s = '0;
        s[STAT_IPL_LSB +: 3] = ipl;
        s[STAT_TIMEOUT]      = timeout;
        s[STAT_OVERRUN]      = overrun;
        s[STAT_BUSY]         = busy;
        s[STAT_RUN]          = run;
        s[STAT_TXN]          = txn;
        return s;
    endfunction

endpackage

// File: rtl/pi_strobe_sync.sv
// Two-flop synchroniser for an asynchronous Pi strobe plus a single-cycle rise detect.
module pi_strobe_sync (
    input  logic clk,
    input  logic reset,
    input  logic strobe,
    output logic rise
);

    logic [1:0] sync;

    // NOTE: sequential state is only ever written with <= so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= 2'b00;
        end else begin
            sync <= {sync[0], strobe};
        end
    end

    assign rise = sync[0] & ~sync[1];

endmodule

// File: rtl/pi_host_port.sv
// Pi-side host register front end: decodes Pi strobes into a bus-cycle descriptor and
// runs the op_req/op_ack/op_done handshake with a busy watchdog and sticky error flags.
module pi_host_port
    import pistorm_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4095
) (
    input  logic        c200m,
    input  logic        reset,
    input  logic [1:0]  pi_a,
    input  logic        pi_rd,
    input  logic        pi_wr,
    input  logic [15:0] pi_d_in,
    output logic [15:0] pi_d_out,
    output logic        pi_d_oe,
    input  logic [2:0]  ipl,
    output logic        op_req,
    output logic        op_rw,
    output logic        op_uds_n,
    output logic        op_lds_n,
    input  logic        op_ack,
    input  logic        op_done,
    output logic        txn_in_progress,
    output logic [15:0] ctrl,
    output logic        reset_req
);

    localparam logic [11:0] WD_LIMIT = 12'(TIMEOUT_CYCLES);

    logic        wr_rise;
    logic        rd_rise;
    host_state_t state;
    logic        a0;
    logic        overrun;
    logic        timeout;
    logic [11:0] wd_cnt;

    pi_strobe_sync u_wr_sync (
        .clk    (c200m),
        .reset  (reset),
        .strobe (pi_wr),
        .rise   (wr_rise)
    );

    pi_strobe_sync u_rd_sync (
        .clk    (c200m),
        .reset  (reset),
        .strobe (pi_rd),
        .rise   (rd_rise)
    );

    logic busy;
    logic lo_wr;
    logic hi_wr;
    logic stat_wr;
    logic wd_expire;
    logic done_now;
    logic overrun_set;
    logic timeout_set;
    logic flag_clr;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        lo_wr   = 1'b0;
        hi_wr   = 1'b0;
        stat_wr = 1'b0;
        if (wr_rise) begin
            case (pi_a)
                REG_ADDR_LO: lo_wr   = 1'b1;
                REG_ADDR_HI: hi_wr   = 1'b1;
                REG_STATUS:  stat_wr = 1'b1;
                REG_DATA:    ;
                default:     ;
            endcase
        end
    end

    assign busy        = (state == ST_REQ) || (state == ST_BUSY);
    assign done_now    = (state == ST_BUSY) && op_done;
    assign wd_expire   = busy && ((wd_cnt + 12'd1) == WD_LIMIT);
    assign overrun_set = busy && (lo_wr || hi_wr);
    // A completion landing on the expiry cycle is a real completion, not a hang.
    assign timeout_set = wd_expire && !done_now;
    assign flag_clr    = stat_wr && pi_d_in[CTRL_CLR_BIT];

    always_ff @(posedge c200m) begin
        if (reset) begin
            state           <= ST_IDLE;
            a0              <= 1'b0;
            op_req          <= 1'b0;
            op_rw           <= 1'b1;
            op_uds_n        <= 1'b1;
            op_lds_n        <= 1'b1;
            txn_in_progress <= 1'b0;
            wd_cnt          <= 12'd0;
            overrun         <= 1'b0;
            timeout         <= 1'b0;
            ctrl            <= 16'h0000;
            pi_d_out        <= 16'h0000;
        end else begin
            if (busy) begin
                wd_cnt <= wd_cnt + 12'd1;
            end

            case (state)
                ST_IDLE, ST_ARMED: begin
                    if (lo_wr) begin
                        a0              <= pi_d_in[0];
                        txn_in_progress <= 1'b1;
                        state           <= ST_ARMED;
                    end else if (hi_wr) begin
                        op_rw           <= pi_d_in[9];
                        op_uds_n        <= pi_d_in[8] ? a0 : 1'b0;
                        op_lds_n        <= pi_d_in[8] ? ~a0 : 1'b0;
                        op_req          <= 1'b1;
                        txn_in_progress <= 1'b1;
                        wd_cnt          <= 12'd0;
                        state           <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (wd_expire) begin
                        op_req          <= 1'b0;
                        txn_in_progress <= 1'b0;
                        state           <= ST_IDLE;
                    end else if (op_ack) begin
                        op_req <= 1'b0;
                        state  <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (op_done || wd_expire) begin
                        txn_in_progress <= 1'b0;
                        state           <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Setting beats clearing so an event in the clear cycle is never lost.
            overrun <= overrun_set | (overrun & ~flag_clr);
            timeout <= timeout_set | (timeout & ~flag_clr);

            if (stat_wr) begin
                ctrl <= pi_d_in;
            end

            if (rd_rise && (pi_a == REG_STATUS)) begin
                pi_d_out <= pack_status(ipl, timeout, overrun, busy,
                                        ctrl[CTRL_RUN_BIT], txn_in_progress);
            end
        end
    end

    assign pi_d_oe   = (pi_a == REG_STATUS) && pi_rd;
    assign reset_req = ~ctrl[CTRL_RUN_BIT];

endmodule

// File: tb/tb_pi_host_port.sv
// Directed bench for pi_host_port: descriptor decode, handshake, overrun, watchdog,
// STATUS readback/clear and synchronous reset.
module tb_pi_host_port;

    logic        c200m = 1'b0;
    logic        reset;
    logic [1:0]  pi_a;
    logic        pi_rd;
    logic        pi_wr;
    logic [15:0] pi_d_in;
    logic [15:0] pi_d_out;
    logic        pi_d_oe;
    logic [2:0]  ipl;
    logic        op_req;
    logic        op_rw;
    logic        op_uds_n;
    logic        op_lds_n;
    logic        op_ack;
    logic        op_done;
    logic        txn_in_progress;
    logic [15:0] ctrl;
    logic        reset_req;

    int errors = 0;
    int checks = 0;

    pi_host_port #(.TIMEOUT_CYCLES(16)) dut (
        .c200m           (c200m),
        .reset           (reset),
        .pi_a            (pi_a),
        .pi_rd           (pi_rd),
        .pi_wr           (pi_wr),
        .pi_d_in         (pi_d_in),
        .pi_d_out        (pi_d_out),
        .pi_d_oe         (pi_d_oe),
        .ipl             (ipl),
        .op_req          (op_req),
        .op_rw           (op_rw),
        .op_uds_n        (op_uds_n),
        .op_lds_n        (op_lds_n),
        .op_ack          (op_ack),
        .op_done         (op_done),
        .txn_in_progress (txn_in_progress),
        .ctrl            (ctrl),
        .reset_req       (reset_req)
    );

    always #5 c200m = ~c200m;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge c200m);
        #1;
    endtask

    // Two low edges first, then the strobe is held for two edges; effects are visible on return.
    task automatic host_write(input logic [1:0] a, input logic [15:0] d);
        tick();
        tick();
        pi_a    = a;
        pi_d_in = d;
        pi_wr   = 1'b1;
        tick();
        tick();
        pi_wr   = 1'b0;
    endtask

    task automatic status_read(input string tag, input logic [15:0] exp);
        tick();
        tick();
        pi_a  = 2'd3;
        pi_rd = 1'b1;
        #1;
        check({tag, "_oe"}, {15'd0, pi_d_oe}, 16'd1);
        tick();
        tick();
        check(tag, pi_d_out, exp);
        pi_rd = 1'b0;
        #1;
        check({tag, "_oe_off"}, {15'd0, pi_d_oe}, 16'd0);
    endtask

    task automatic pulse_ack();
        op_ack = 1'b1;
        tick();
        op_ack = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},  {15'd0, op_req},          16'd0);
        check({tag, "_rw"},   {15'd0, op_rw},           16'd1);
        check({tag, "_uds"},  {15'd0, op_uds_n},        16'd1);
        check({tag, "_lds"},  {15'd0, op_lds_n},        16'd1);
        check({tag, "_txn"},  {15'd0, txn_in_progress}, 16'd0);
        check({tag, "_ctrl"}, ctrl,                     16'h0000);
        check({tag, "_rreq"}, {15'd0, reset_req},       16'd1);
        check({tag, "_dout"}, pi_d_out,                 16'h0000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench time limit");
    end

    initial begin
        reset   = 1'b1;
        pi_a    = 2'd0;
        pi_rd   = 1'b0;
        pi_wr   = 1'b0;
        pi_d_in = 16'h0000;
        ipl     = 3'b101;
        op_ack  = 1'b0;
        op_done = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_reset_outputs("rst");

        // Byte read at odd address: ADDR_LO=1 then ADDR_HI=0x0300.
        host_write(2'd1, 16'h0001);
        check("armed_txn", {15'd0, txn_in_progress}, 16'd1);
        check("armed_req", {15'd0, op_req}, 16'd0);
        tick();
        tick();
        pi_a    = 2'd2;
        pi_d_in = 16'h0300;
        pi_wr   = 1'b1;
        tick();
        check("req_edge_k", {15'd0, op_req}, 16'd0);
        tick();
        check("req_edge_k1", {15'd0, op_req}, 16'd1);
        pi_wr = 1'b0;
        check("t1_rw",  {15'd0, op_rw},    16'd1);
        check("t1_uds", {15'd0, op_uds_n}, 16'd1);
        check("t1_lds", {15'd0, op_lds_n}, 16'd0);
        check("t1_txn", {15'd0, txn_in_progress}, 16'd1);

        pulse_ack();
        check("t1_ack_req", {15'd0, op_req}, 16'd0);
        check("t1_busy_txn", {15'd0, txn_in_progress}, 16'd1);
        repeat (9) tick();
        op_done = 1'b1;
        tick();
        op_done = 1'b0;
        check("t1_done_txn", {15'd0, txn_in_progress}, 16'd0);
        status_read("t1_stat", 16'hA000);

        // Word write with no ADDR_LO.
        host_write(2'd2, 16'h0000);
        check("t3_req", {15'd0, op_req},   16'd1);
        check("t3_rw",  {15'd0, op_rw},    16'd0);
        check("t3_uds", {15'd0, op_uds_n}, 16'd0);
        check("t3_lds", {15'd0, op_lds_n}, 16'd0);
        status_read("t3_stat_req", 16'hA005);
        pulse_ack();

        // ADDR_LO write landing on the op_done edge: ignored, flags overrun.
        tick();
        tick();
        pi_a    = 2'd1;
        pi_d_in = 16'h0000;
        pi_wr   = 1'b1;
        tick();
        op_done = 1'b1;
        tick();
        op_done = 1'b0;
        pi_wr   = 1'b0;
        check("t4_txn", {15'd0, txn_in_progress}, 16'd0);
        check("t4_uds", {15'd0, op_uds_n}, 16'd0);
        check("t4_lds", {15'd0, op_lds_n}, 16'd0);
        status_read("t4_stat_ovr", 16'hA008);
        host_write(2'd3, 16'h8002);
        check("t4_ctrl", ctrl, 16'h8002);
        check("t4_rreq", {15'd0, reset_req}, 16'd0);
        status_read("t4_stat_clr", 16'hA002);

        // Byte write reuses the held a0 (still 1); then no ack -> watchdog at 16 cycles.
        host_write(2'd2, 16'h0100);
        check("t5_req", {15'd0, op_req},   16'd1);
        check("t5_rw",  {15'd0, op_rw},    16'd0);
        check("t5_uds", {15'd0, op_uds_n}, 16'd1);
        check("t5_lds", {15'd0, op_lds_n}, 16'd0);
        repeat (5) tick();
        op_done = 1'b1;
        tick();
        op_done = 1'b0;
        repeat (9) tick();
        check("t5_req_c15", {15'd0, op_req}, 16'd1);
        check("t5_txn_c15", {15'd0, txn_in_progress}, 16'd1);
        tick();
        check("t5_req_c16", {15'd0, op_req}, 16'd0);
        check("t5_txn_c16", {15'd0, txn_in_progress}, 16'd0);
        status_read("t5_stat_to", 16'hA012);

        // Plain STATUS write keeps sticky timeout; reset mid-BUSY aborts everything.
        host_write(2'd3, 16'h0002);
        check("t6_ctrl", ctrl, 16'h0002);
        check("t6_rreq", {15'd0, reset_req}, 16'd0);
        status_read("t6_stat", 16'hA012);
        host_write(2'd1, 16'h0000);
        host_write(2'd2, 16'h0200);
        check("t6_rw",  {15'd0, op_rw},    16'd1);
        check("t6_uds", {15'd0, op_uds_n}, 16'd0);
        check("t6_lds", {15'd0, op_lds_n}, 16'd0);
        pulse_ack();
        check("t6_busy_req", {15'd0, op_req}, 16'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_outputs("t6_rst");
        op_done = 1'b1;
        tick();
        op_done = 1'b0;
        status_read("t6_stat_after", 16'hA000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
